program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 28 ++
 tb/tb_program_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter: a single WIDTH-bit register that resets, loads a jump
// target, or advances by INCR each rising clock edge (priority in that order).
module program_counter #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0,
  parameter int unsigned          INCR       = 4
) (
  input  logic             PC_rst,
  input  logic             PC_clk,
  input  logic             PC_jump_enb,
  input  logic [WIDTH-1:0] PC_jump_add,
  output logic [WIDTH-1:0] PC_counter
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INCR);

  // Increment wraps modulo 2^WIDTH; jump targets are taken unmasked.
  always_ff @(posedge PC_clk) begin
    if (PC_rst) begin
      PC_counter <= RESET_ADDR;
    end else if (PC_jump_enb) begin
      PC_counter <= PC_jump_add;
    end else begin
      PC_counter <= PC_counter + STEP;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: table-driven vectors plus
// hand-written multi-cycle sequences (long run, glitches, non-default params).
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        jen;
  logic [31:0] jadd;
  logic [31:0] pc;
  logic [15:0] pc16;

  int total = 0;
  int bad   = 0;

  program_counter dut (
    .PC_rst      (rst),
    .PC_clk      (clk),
    .PC_jump_enb (jen),
    .PC_jump_add (jadd),
    .PC_counter  (pc)
  );

  // Narrow instance with non-default reset address and step.
  program_counter #(
    .WIDTH      (16),
    .RESET_ADDR (16'h0100),
    .INCR       (2)
  ) dut16 (
    .PC_rst      (rst),
    .PC_clk      (clk),
    .PC_jump_enb (jen),
    .PC_jump_add (jadd[15:0]),
    .PC_counter  (pc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        jen;
    logic [31:0] jadd;
    logic [31:0] exp;
  } vec_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic j, input logic [31:0] a);
    rst  = r;
    jen  = j;
    jadd = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    jen  = 1'b0;
    jadd = '0;

    // reset then count
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C};
    // reset beats jump
    vecs[4]  = '{1'b1, 1'b1, 32'd500,       32'h0000_0000};
    // held jump, then release
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0044};
    // wrap at top of address space
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    // unaligned jump taken exactly
    vecs[12] = '{1'b0, 1'b1, 32'h1234_5673, 32'h1234_5673};
    // reach 0x20, mid-run reset, resume
    vecs[13] = '{1'b0, 1'b1, 32'h0000_001C, 32'h0000_001C};
    vecs[14] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0020};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};

    @(negedge clk);
    for (int i = 0; i < int'(NVEC); i++) begin
      step(vecs[i].rst, vecs[i].jen, vecs[i].jadd);
      check($sformatf("vec%0d", i), pc, vecs[i].exp);
    end

    // Long run: 25 increments from 0 reaches 100, then jump to 500.
    step(1'b1, 1'b0, 32'h0);
    check("run_reset", pc, 32'd0);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (k % 5 == 0) check($sformatf("run_%0d", k), pc, 32'(4 * k));
    end
    step(1'b0, 1'b1, 32'd500);
    check("run_jump", pc, 32'd500);
    step(1'b0, 1'b0, 32'd500);
    check("run_jump_p1", pc, 32'd504);
    step(1'b0, 1'b0, 32'd500);
    check("run_jump_p2", pc, 32'd508);

    // Glitches on reset and jump enable between edges do nothing.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1 jadd = 32'hDEAD_BEEC;
    jen = 1'b1;
    #1 jen = 1'b0;
    check("glitch_hold", pc, 32'd508);
    @(posedge clk);
    #1;
    check("glitch_next", pc, 32'd512);

    // Non-default parameters: reset address, step and 16-bit wrap.
    step(1'b1, 1'b0, 32'h0);
    check("p16_reset", 32'(pc16), 32'h0100);
    step(1'b0, 1'b0, 32'h0);
    check("p16_incr", 32'(pc16), 32'h0102);
    step(1'b0, 1'b1, 32'h0000_FFFE);
    check("p16_jump", 32'(pc16), 32'hFFFE);
    step(1'b0, 1'b0, 32'h0);
    check("p16_wrap", 32'(pc16), 32'h0000);
    check("p32_after", pc, 32'h0001_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
